// File: rtl/kernel_loader_if.sv
// Handshake/status bundle between a coefficient source and kernel_loader.
interface kernel_loader_if #(parameter int COEF_W = 3);
  logic              start;
  logic              in_valid;
  logic [COEF_W-1:0] in_data;
  logic              in_ready;
  logic [3:0]        load_sel;
  logic              kernel_valid;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, load_sel, kernel_valid
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, load_sel, kernel_valid
  );
endinterface

// File: rtl/kernel_loader.sv
// Loads a serial stream of nine 3x3 kernel coefficients into held position
// registers in fixed select-code order and flags when the kernel is complete.
//
// state | meaning
// IDLE  | waiting for start, nothing resident
// LOAD  | accepting coefficients, idx = next slot
// DONE  | all nine slots hold the current kernel
module kernel_loader #(
  parameter int COEF_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  kernel_loader_if.slave    bus,
  output logic [COEF_W-1:0] tl_k,
  output logic [COEF_W-1:0] tr_k,
  output logic [COEF_W-1:0] bl_k,
  output logic [COEF_W-1:0] br_k,
  output logic [COEF_W-1:0] r_k,
  output logic [COEF_W-1:0] l_k,
  output logic [COEF_W-1:0] t_k,
  output logic [COEF_W-1:0] b_k,
  output logic [COEF_W-1:0] c_k
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        idx, idx_nxt;
  logic              clr_all, wr_en;
  logic [COEF_W-1:0] coef [9];

  function automatic logic [3:0] sel_code(input logic [3:0] i);
    case (i)
      4'd0:    sel_code = 4'b0001;
      4'd1:    sel_code = 4'b0010;
      4'd2:    sel_code = 4'b0011;
      4'd3:    sel_code = 4'b0100;
      4'd4:    sel_code = 4'b0101;
      4'd5:    sel_code = 4'b0110;
      4'd6:    sel_code = 4'b0111;
      4'd7:    sel_code = 4'b1000;
      4'd8:    sel_code = 4'b1111;
      default: sel_code = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 4'd0;
      for (int i = 0; i < 9; i++) coef[i] <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      for (int i = 0; i < 9; i++) begin
        if (clr_all)
          coef[i] <= '0;
        else if (wr_en && idx == 4'(i))
          coef[i] <= bus.in_data;
      end
    end
  end

  // start always wins over a same-cycle transfer
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clr_all   = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = LOAD;
          idx_nxt   = 4'd0;
          clr_all   = 1'b1;
        end
      end
      LOAD: begin
        if (bus.start) begin
          idx_nxt = 4'd0;
          clr_all = 1'b1;
        end else if (bus.in_valid) begin
          wr_en = 1'b1;
          if (idx == 4'd8) begin
            state_nxt = DONE;
            idx_nxt   = 4'd0;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 4'd0;
      end
    endcase
  end

  assign bus.in_ready     = (state == LOAD);
  assign bus.kernel_valid = (state == DONE);
  assign bus.load_sel     = (state == LOAD) ? sel_code(idx) : 4'b0000;

  assign tl_k = coef[0];
  assign tr_k = coef[1];
  assign bl_k = coef[2];
  assign br_k = coef[3];
  assign r_k  = coef[4];
  assign l_k  = coef[5];
  assign t_k  = coef[6];
  assign b_k  = coef[7];
  assign c_k  = coef[8];

endmodule

// File: tb/tb_kernel_loader.sv
// Randomized self-checking bench for kernel_loader against a slot-array model.
module tb_kernel_loader;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] tl_k, tr_k, bl_k, br_k, r_k, l_k, t_k, b_k, c_k;
  logic [W-1:0] dut_k [9];

  kernel_loader_if #(.COEF_W(W)) bus ();

  kernel_loader #(.COEF_W(W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .tl_k(tl_k), .tr_k(tr_k), .bl_k(bl_k), .br_k(br_k), .r_k(r_k),
    .l_k(l_k), .t_k(t_k), .b_k(b_k), .c_k(c_k)
  );

  always #5 clk = ~clk;

  assign dut_k[0] = tl_k; assign dut_k[1] = tr_k; assign dut_k[2] = bl_k;
  assign dut_k[3] = br_k; assign dut_k[4] = r_k;  assign dut_k[5] = l_k;
  assign dut_k[6] = t_k;  assign dut_k[7] = b_k;  assign dut_k[8] = c_k;

  int checks = 0;
  int errors = 0;

  // reference model: resident slot values and count of accepted beats
  logic [W-1:0] m_k [9];
  int           m_n;
  logic [3:0]   codes [9];
  logic [W-1:0] vals [9];

  initial begin
    codes[0] = 4'd1; codes[1] = 4'd2; codes[2] = 4'd3; codes[3] = 4'd4;
    codes[4] = 4'd5; codes[5] = 4'd6; codes[6] = 4'd7; codes[7] = 4'd8;
    codes[8] = 4'd15;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_k[i] = '0;
    m_n = 0;
  endtask

  task automatic pulse_start(input logic with_valid, input logic [W-1:0] d);
    bus.start    = 1'b1;
    bus.in_valid = with_valid;
    bus.in_data  = d;
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.load_sel !== 4'd1 || bus.kernel_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_entry: ready=%b sel=%0d kv=%b required ready=1 sel=1 kv=0",
               bus.in_ready, bus.load_sel, bus.kernel_valid);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dut_k[i] !== '0) begin
        errors++;
        $display("FAIL start_clear slot%0d: got %0d required 0", i, dut_k[i]);
      end
    end
  endtask

  // gap_mode 0: valid held high, 1: alternate 1/0, 2: random gaps
  task automatic feed(input int nmax, input int gap_mode, output int cyc);
    logic v;
    cyc = 0;
    while (m_n < nmax && cyc < 200) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? vals[m_n] : W'($urandom);
      checks++;
      if (bus.load_sel !== codes[m_n] || bus.in_ready !== 1'b1 || bus.kernel_valid !== 1'b0) begin
        errors++;
        $display("FAIL load_sel beat%0d: sel=%0d ready=%b kv=%b required sel=%0d ready=1 kv=0",
                 m_n, bus.load_sel, bus.in_ready, bus.kernel_valid, codes[m_n]);
      end
      step();
      cyc++;
      if (v) begin
        m_k[m_n] = vals[m_n];
        m_n++;
      end
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (dut_k[i] !== m_k[i]) begin
          errors++;
          $display("FAIL slot%0d after beat: got %0d required %0d", i, dut_k[i], m_k[i]);
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (m_n < nmax) begin
      errors++;
      $display("FAIL feed_timeout: accepted %0d required %0d", m_n, nmax);
    end
    if (nmax == 9) begin
      checks++;
      if (bus.kernel_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.load_sel !== 4'd0) begin
        errors++;
        $display("FAIL done_state: kv=%b ready=%b sel=%0d required kv=1 ready=0 sel=0",
                 bus.kernel_valid, bus.in_ready, bus.load_sel);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.load_sel !== 4'd0 || bus.kernel_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready=%b sel=%0d kv=%b required 0 0 0",
               tag, bus.in_ready, bus.load_sel, bus.kernel_valid);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dut_k[i] !== '0) begin
        errors++;
        $display("FAIL %s slot%0d: got %0d required 0", tag, i, dut_k[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 3'd5;
    step();
    step();
    check_reset_values("reset_held");
    rst = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
    step();
    check_reset_values("reset_release");
    model_clear();
  endtask

  task automatic test_full_load();
    int cyc;
    vals[0] = 3'd1; vals[1] = 3'd2; vals[2] = 3'd3; vals[3] = 3'd4; vals[4] = 3'd5;
    vals[5] = 3'd6; vals[6] = 3'd7; vals[7] = 3'd0; vals[8] = 3'd5;
    pulse_start(1'b0, '0);
    feed(9, 0, cyc);
    checks++;
    if (cyc + 1 != 10) begin
      errors++;
      $display("FAIL full_latency: kv after %0d cycles required 10", cyc + 1);
    end
  endtask

  task automatic test_stalled();
    int cyc;
    pulse_start(1'b0, '0);
    feed(9, 1, cyc);
    checks++;
    if (cyc + 1 != 18) begin
      errors++;
      $display("FAIL stall_latency: kv after %0d cycles required 18", cyc + 1);
    end
  endtask

  task automatic test_restart();
    int cyc;
    for (int i = 0; i < 9; i++) vals[i] = W'($urandom);
    pulse_start(1'b0, '0);
    feed(4, 2, cyc);
    pulse_start(1'b1, 3'd5);
    for (int i = 0; i < 9; i++) vals[i] = 3'd6;
    feed(9, 0, cyc);
  endtask

  task automatic test_reload();
    int cyc;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom);
      step();
      checks++;
      if (bus.kernel_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL done_hold: kv=%b ready=%b required kv=1 ready=0",
                 bus.kernel_valid, bus.in_ready);
      end
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (dut_k[i] !== m_k[i]) begin
          errors++;
          $display("FAIL done_hold slot%0d: got %0d required %0d", i, dut_k[i], m_k[i]);
        end
      end
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) vals[i] = W'($urandom);
    pulse_start(1'b0, '0);
    feed(9, 2, cyc);
  endtask

  task automatic test_reset_mid();
    int cyc;
    for (int i = 0; i < 9; i++) vals[i] = W'($urandom_range(1, 7));
    pulse_start(1'b0, '0);
    feed(5, 0, cyc);
    rst = 1'b1; bus.in_valid = 1'b1; bus.start = 1'b1;
    step();
    rst = 1'b0; bus.in_valid = 1'b0; bus.start = 1'b0;
    check_reset_values("reset_mid");
    model_clear();
    pulse_start(1'b0, '0);
    feed(9, 0, cyc);
  endtask

  task automatic test_random();
    int cyc;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 9; i++) vals[i] = W'($urandom);
      pulse_start(1'b0, '0);
      feed(9, 2, cyc);
      checks++;
      if (cyc < 9) begin
        errors++;
        $display("FAIL random_latency: %0d cycles required at least 9", cyc);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    model_clear();
    test_reset();
    test_full_load();
    test_stalled();
    test_restart();
    test_reload();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/kernel_loader.md
# kernel_loader

Write-side counterpart of the kernel coefficient select path. Accepts a serial stream of 3x3 kernel coefficients over a valid/ready handshake and distributes them, in fixed select-code order, into nine held position registers (tl, tr, bl, br, r, l, t, b, c). It sits upstream of the kernel coefficient mux and signals when a complete kernel is resident.

## Interface
- COEF_W, 3, width of one kernel coefficient
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin (or restart) loading a new kernel
- in_valid  in  1  coefficient on in_data is valid
- in_data  in  COEF_W  coefficient value
- in_ready  out  1  loader accepts a coefficient this cycle
- load_sel  out  4  select code of the slot the next accepted coefficient writes; 4'b0000 when not loading
- kernel_valid  out  1  all nine slots hold the current kernel
- tl_k, tr_k, bl_k, br_k, r_k, l_k, t_k, b_k, c_k  out  COEF_W each  held coefficient per kernel position

## Operation
- Slot order and select codes (fixed): tl=0001, tr=0010, bl=0011, br=0100, r=0101, l=0110, t=0111, b=1000, c=1111. Index 0..8 maps to these codes in that order.
- Handshake: transfer occurs on a rising edge where in_valid && in_ready. in_data is written to the slot named by load_sel, index increments.
- States:
  - IDLE: in_ready=0, kernel_valid=0, load_sel=0. start -> LOAD, index=0.
  - LOAD: in_ready=1, load_sel=code(index). Transfer at index 8 -> DONE. start while in LOAD -> stays LOAD, index=0, partial kernel discarded (a simultaneous transfer in that cycle is ignored).
  - DONE: in_ready=0, kernel_valid=1, load_sel=0. Coefficient outputs held. start -> LOAD, index=0.
- On entry to LOAD (any start accepted) all nine coefficient registers clear to 0 and kernel_valid drops.
- in_valid with in_ready=0 is ignored; no data captured, no error.
- Coefficients are stored unmodified; no arithmetic, no width change.
- rst overrides everything including start, at any point mid-load.

## Timing
- Reset values: state IDLE, index 0, in_ready 0, load_sel 4'b0000, kernel_valid 0, all *_k = 0.
- in_ready, load_sel, kernel_valid decode from registered state/index only (no combinational path from inputs).
- start at edge N: at cycle N+1 state=LOAD, in_ready=1, load_sel=0001, coefficients=0, kernel_valid=0.
- Transfer at edge N: slot value visible at cycle N+1; load_sel advances at N+1.
- Ninth transfer (load_sel=1111) at edge N: c_k valid, kernel_valid=1, in_ready=0 at N+1.
- Minimum load time: 9 cycles after first in_ready with in_valid held high; in_valid gaps stall without loss.
- rst asserted at edge N: reset values at N+1 regardless of state.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1, start=1 -> all outputs 0, in_ready=0, state IDLE after release.
- Full load, back-to-back: start, then in_data 1,2,3,4,5,6,7,0,5 with in_valid high -> tl_k=1 tr_k=2 bl_k=3 br_k=4 r_k=5 l_k=6 t_k=7 b_k=0 c_k=5; kernel_valid=1 exactly 10 cycles after start edge; load_sel sequence 1,2,3,4,5,6,7,8,15.
- Stalled load: same data with in_valid toggling 1/0 -> identical final registers; load_sel holds during gaps; kernel_valid 18 cycles after start.
- Restart mid-load: start, load 4 coefficients, pulse start with in_valid=1 -> that beat ignored, all slots 0, load_sel=0001; then 9 values of 6 -> all slots 6, kernel_valid=1.
- Reload from DONE: after full load, in_valid alone -> no change; start -> kernel_valid=0 and slots 0 next cycle; new 9 values load correctly.
- Reset mid-load: rst after 5 transfers -> all outputs at reset values next cycle; subsequent start/load completes normally.
